// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared FSM state type and ROM content function
package rom_stream_pkg;

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic logic [31:0] word(input logic [31:0] a, input int unsigned addr_w);
        int unsigned h;
        logic [31:0] m;
        h = addr_w / 2;
        m = (32'd1 << h) - 32'd1;
        // Sum of the low and high address halves, carry dropped at half width
        return ((a & m) + ((a >> h) & m)) & m;
    endfunction

endpackage

// File: rtl/rom_stream_if.sv
// rom_stream_if: burst request and word stream handshake bundle
interface rom_stream_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_len;
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout;
    logic              dout_last;
    logic              busy;

    modport master (
        output req_valid, req_addr, req_len, dout_ready,
        input  req_ready, dout_valid, dout, dout_last, busy
    );

    modport slave (
        input  req_valid, req_addr, req_len, dout_ready,
        output req_ready, dout_valid, dout, dout_last, busy
    );
endinterface

// File: rtl/rom_table.sv
// rom_table: combinational address-to-word lookup of the fixed ROM
module rom_table #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    import rom_stream_pkg::*;

    assign data = DATA_W'(word(32'(addr), ADDR_W));
endmodule

// File: rtl/rom_stream.sv
// rom_stream: streams a burst of ROM words from a start address with valid/ready flow control
module rom_stream #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2
) (
    input logic       clk,
    input logic       rst,
    rom_stream_if.slave bus
);
    import rom_stream_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rem;
    logic [ADDR_W-1:0] look_addr;
    logic [DATA_W-1:0] look_data;
    logic [DATA_W-1:0] dout_q;
    logic              last_q;
    logic              accept;
    logic              fire;

    assign accept         = bus.req_valid && (state == IDLE);
    assign fire           = (state == STREAM) && bus.dout_ready;
    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state == STREAM);
    assign bus.dout_valid = (state == STREAM);
    assign bus.dout       = dout_q;
    assign bus.dout_last  = last_q;

    // In IDLE look up the incoming start word, while streaming look up the following word
    assign look_addr = (state == IDLE) ? bus.req_addr : addr + 1'b1;

    rom_table #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
        .addr (look_addr),
        .data (look_data)
    );

    // Next state: accept starts a burst, transfer of the last beat ends it
    always_comb begin
        state_next = state;
        state_next = accept ? STREAM : (fire && last_q) ? IDLE : state;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Output word register; rem counts beats left after the one on dout, so len=0 yields 2^ADDR_W beats
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            rem    <= '0;
            dout_q <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            addr   <= bus.req_addr;
            rem    <= bus.req_len - 1'b1;
            dout_q <= look_data;
            last_q <= (bus.req_len == ADDR_W'(1));
        end else if (fire) begin
            addr   <= look_addr;
            rem    <= rem - 1'b1;
            dout_q <= last_q ? '0 : look_data;
            last_q <= (rem == ADDR_W'(1));
        end
    end
endmodule

// File: tb/tb_rom_stream.sv
// tb_rom_stream: directed self-checking bench for rom_stream at ADDR_W=4, DATA_W=2
module tb_rom_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    localparam logic [1:0] BASIC_EXP [4]  = '{2'd0, 2'd1, 2'd2, 2'd3};
    localparam logic [1:0] WRAP_EXP  [4]  = '{2'd1, 2'd2, 2'd0, 2'd1};
    localparam logic [1:0] FULL_EXP  [16] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3,
                                             2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};

    rom_stream_if #(.ADDR_W(4), .DATA_W(2)) bus ();

    rom_stream #(.ADDR_W(4), .DATA_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", nvec);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [3:0] a, input logic [3:0] len);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = len;
        step();
        bus.req_valid = 1'b0;
        bus.req_addr  = 4'd0;
        bus.req_len   = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 2'd0 || bus.busy !== 1'b0 || bus.dout_last !== 1'b0) begin
            nerr++;
            $display("FAIL reset_held: valid=%b dout=%0d busy=%b last=%b, want 0 0 0 0",
                     bus.dout_valid, bus.dout, bus.busy, bus.dout_last);
        end
        rst = 1'b0;
        step();
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 2'd0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release: valid=%b dout=%0d busy=%b ready=%b, want 0 0 0 1",
                     bus.dout_valid, bus.dout, bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_basic();
        bus.dout_ready = 1'b1;
        request(4'd0, 4'd4);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== BASIC_EXP[i] || bus.dout_last !== (i == 3) || bus.busy !== 1'b1) begin
                nerr++;
                $display("FAIL basic_beat%0d: valid=%b dout=%0d last=%b busy=%b, want 1 %0d %b 1",
                         i, bus.dout_valid, bus.dout, bus.dout_last, bus.busy, BASIC_EXP[i], (i == 3));
            end
            step();
        end
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.dout_last !== 1'b0) begin
            nerr++;
            $display("FAIL basic_end: valid=%b ready=%b busy=%b last=%b, want 0 1 0 0",
                     bus.dout_valid, bus.req_ready, bus.busy, bus.dout_last);
        end
    endtask

    task automatic test_wrap();
        bus.dout_ready = 1'b1;
        request(4'd14, 4'd4);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== WRAP_EXP[i] || bus.dout_last !== (i == 3)) begin
                nerr++;
                $display("FAIL wrap_beat%0d: valid=%b dout=%0d last=%b, want 1 %0d %b",
                         i, bus.dout_valid, bus.dout, bus.dout_last, WRAP_EXP[i], (i == 3));
            end
            step();
        end
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL wrap_end: valid=%b ready=%b, want 0 1", bus.dout_valid, bus.req_ready);
        end
    endtask

    task automatic test_backpressure();
        bus.dout_ready = 1'b1;
        request(4'd8, 4'd3);
        nvec++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 2'd2 || bus.dout_last !== 1'b0) begin
            nerr++;
            $display("FAIL bp_beat0: valid=%b dout=%0d last=%b, want 1 2 0", bus.dout_valid, bus.dout, bus.dout_last);
        end
        step();
        bus.dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== 2'd3 || bus.dout_last !== 1'b0) begin
                nerr++;
                $display("FAIL bp_hold%0d: valid=%b dout=%0d last=%b, want 1 3 0",
                         k, bus.dout_valid, bus.dout, bus.dout_last);
            end
            if (k < 2) step();
        end
        bus.dout_ready = 1'b1;
        step();
        nvec++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 2'd0 || bus.dout_last !== 1'b1) begin
            nerr++;
            $display("FAIL bp_beat2: valid=%b dout=%0d last=%b, want 1 0 1", bus.dout_valid, bus.dout, bus.dout_last);
        end
        step();
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.dout_last !== 1'b0) begin
            nerr++;
            $display("FAIL bp_end: valid=%b ready=%b last=%b, want 0 1 0", bus.dout_valid, bus.req_ready, bus.dout_last);
        end
    endtask

    task automatic test_full_length();
        bus.dout_ready = 1'b1;
        request(4'd5, 4'd0);
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== FULL_EXP[i] || bus.dout_last !== (i == 15) || bus.req_ready !== 1'b0) begin
                nerr++;
                $display("FAIL full_beat%0d: valid=%b dout=%0d last=%b ready=%b, want 1 %0d %b 0",
                         i, bus.dout_valid, bus.dout, bus.dout_last, bus.req_ready, FULL_EXP[i], (i == 15));
            end
            bus.req_valid = (i == 7);
            bus.req_addr  = (i == 7) ? 4'd3 : 4'd0;
            bus.req_len   = (i == 7) ? 4'd1 : 4'd0;
            step();
        end
        bus.req_valid = 1'b0;
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL full_end: valid=%b ready=%b busy=%b, want 0 1 0", bus.dout_valid, bus.req_ready, bus.busy);
        end
        step();
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL full_no_queue: valid=%b busy=%b, want 0 0", bus.dout_valid, bus.busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        bus.dout_ready = 1'b1;
        request(4'd0, 4'd8);
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== BASIC_EXP[i]) begin
                nerr++;
                $display("FAIL rmb_beat%0d: valid=%b dout=%0d, want 1 %0d", i, bus.dout_valid, bus.dout, BASIC_EXP[i]);
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dout !== 2'd0 || bus.dout_last !== 1'b0) begin
            nerr++;
            $display("FAIL rmb_reset: valid=%b busy=%b dout=%0d last=%b, want 0 0 0 0",
                     bus.dout_valid, bus.busy, bus.dout, bus.dout_last);
        end
        step();
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rmb_idle: valid=%b ready=%b, want 0 1", bus.dout_valid, bus.req_ready);
        end
        request(4'd3, 4'd1);
        nvec++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 2'd3 || bus.dout_last !== 1'b1) begin
            nerr++;
            $display("FAIL rmb_single: valid=%b dout=%0d last=%b, want 1 3 1", bus.dout_valid, bus.dout, bus.dout_last);
        end
        step();
        nvec++;
        if (bus.dout_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.dout_last !== 1'b0) begin
            nerr++;
            $display("FAIL rmb_single_end: valid=%b ready=%b last=%b, want 0 1 0",
                     bus.dout_valid, bus.req_ready, bus.dout_last);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = 4'd0;
        bus.req_len    = 4'd0;
        bus.dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_full_length();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rom_stream.md
ROM_STREAM -- requirements
Module: rom_stream

Interface
REQ-001 Parameter ADDR_W, default 4, address width; SHALL be even and >= 2.
REQ-002 Parameter DATA_W, default 2, data word width; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  burst request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_addr  input  ADDR_W  burst start address.
REQ-008 req_len  input  ADDR_W  burst length in words; 0 encodes 2^ADDR_W.
REQ-009 dout_valid  output  1  dout holds a valid word.
REQ-010 dout_ready  input  1  consumer accepts dout this cycle.
REQ-011 dout  output  DATA_W  ROM word.
REQ-012 dout_last  output  1  current word is the final beat of the burst.
REQ-013 busy  output  1  a burst is in progress.

Function
REQ-014 ROM content SHALL be fixed: word(a) = (a[ADDR_W/2-1:0] + a[ADDR_W-1:ADDR_W/2]) truncated to DATA_W bits; the carry is discarded (e.g. a=4'b1010 gives 0 at DATA_W=2).
REQ-015 FSM states: IDLE, STREAM.
REQ-016 IDLE: req_ready=1, dout_valid=0, busy=0.
REQ-017 Request accepted when req_valid && req_ready; state moves to STREAM, address and remaining count are captured.
REQ-018 First word SHALL appear on dout with dout_valid=1 in the cycle after acceptance (1-cycle latency); dout is registered.
REQ-019 STREAM: req_ready=0, busy=1; req_valid is ignored and no request is queued.
REQ-020 A beat transfers when dout_valid && dout_ready; on a transfer the next word, at address+1, is presented in the following cycle, giving one word per cycle under full throughput.
REQ-021 Address increment SHALL wrap modulo 2^ADDR_W.
REQ-022 While dout_valid && !dout_ready, dout, dout_last and dout_valid SHALL hold stable.
REQ-023 dout_last=1 exactly on the final beat; dout_last=0 whenever dout_valid=0.
REQ-024 On transfer of the last beat: state becomes IDLE, dout_valid=0 and req_ready=1 in the next cycle; there is no back-to-back burst overlap.
REQ-025 req_len=1 SHALL produce a single beat with dout_last=1.
REQ-026 req_len=0 SHALL produce 2^ADDR_W beats, covering every address exactly once.

Reset
REQ-027 When rst=1 at a clock edge: state=IDLE; dout_valid=0, dout=0, dout_last=0, busy=0; req_ready=1 in the following cycle.
REQ-028 rst SHALL take priority over every handshake, including during STREAM; the burst in progress is discarded and produces no further beats.

Structure
REQ-029 Shared package rom_stream_pkg SHALL hold the state enum (IDLE, STREAM) and the ROM content function word(a).
REQ-030 Sub-module rom_table: combinational address-to-word lookup, parametrised by ADDR_W and DATA_W; rom_stream instantiates it once.

Verification (ADDR_W=4, DATA_W=2)
REQ-031 Reset: hold rst for 2 cycles, then release -> dout_valid=0, dout=0, busy=0, req_ready=1.
REQ-032 addr=0, len=4, dout_ready=1 -> dout 0,1,2,3 on 4 consecutive cycles; dout_last only on the 4th; req_ready=1 on the next cycle.
REQ-033 Wrap: addr=14, len=4 -> dout 1,2,0,1 (addresses 14,15,0,1); dout_last on the 4th beat.
REQ-034 Backpressure: addr=8, len=3, dout_ready low for 2 cycles during beat 2 -> dout stays at 3 and stable; sequence 2,3,0; dout_last on 0.
REQ-035 Full length: addr=5, len=0 -> 16 beats; first 2, last 1 (address 4); dout_last only on the 16th; req_valid pulsed mid-burst has no effect.
REQ-036 Reset mid-burst: addr=0, len=8, rst asserted after beat 2 -> next cycle dout_valid=0, busy=0; new request addr=3, len=1 -> single beat 3 with dout_last=1.
